aes_128_unroll: RTL and testbench
=================================

AES_128_UNROLL -- requirements
Module: aes_128_unroll

Interface
REQ-001 SHALL have parameter UNROLL, default 1: AES rounds computed per clock; legal values 1, 2, 5, 10.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  plaintext/key offered.
REQ-005 SHALL have port in_ready  output  1  block can accept input this cycle.
REQ-006 SHALL have port in_data  input  128  plaintext, byte 0 in [127:120].
REQ-007 SHALL have port key  input  128  cipher key, sampled with in_data.
REQ-008 SHALL have port out_valid  output  1  out_data holds a finished ciphertext.
REQ-009 SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-010 SHALL have port out_data  output  128  ciphertext, same byte order as in_data.

Function
REQ-011 SHALL implement FIPS-197 AES-128 encryption, with round keys generated on the fly, one key-expansion step per round.
REQ-012 SHALL use FSM states IDLE, RUN, DONE; IDLE->RUN on input handshake; RUN->DONE when the round counter reaches 10; DONE->IDLE on output handshake without a new input handshake; DONE->RUN on output and input handshake in the same cycle.
REQ-013 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready), combinationally.
REQ-014 SHALL, on input handshake, register state = in_data ^ key and key_reg = key, and clear the round counter.
REQ-015 SHALL, in RUN, apply UNROLL chained rounds per cycle and advance the counter by UNROLL; round 10 omits MixColumns.
REQ-016 SHALL select Rcon by absolute round index (01,02,04,08,10,20,40,80,1b,36), independent of UNROLL.
REQ-017 SHALL assert out_valid exactly N=10/UNROLL clock edges after the accepting edge.
REQ-018 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL ignore in_valid while in_ready=0, and ignore out_ready while out_valid=0.
REQ-020 SHALL sustain a throughput of one block per N+1 cycles with in_valid=out_ready=1 held.
REQ-021 SHALL fail elaboration for any UNROLL not in {1,2,5,10}.

Reset
REQ-022 SHALL, while rst=1, force FSM=IDLE, out_valid=0, in_ready=0, round counter=0, out_data=0, chain register=0.
REQ-023 SHALL, on rst during RUN or DONE, discard the in-flight block and produce no output handshake for it.

Configuration
REQ-024 SHALL, with macro AES_CBC_EN defined, add input ports iv[127:0] and chain_start[1], both sampled on input handshake.
REQ-025 SHALL, with AES_CBC_EN defined, XOR the plaintext with iv when chain_start=1, else with the chain register, before the initial AddRoundKey.
REQ-026 SHALL, with AES_CBC_EN defined, load the chain register with out_data on each output handshake.
REQ-027 SHALL, with AES_CBC_EN defined and simultaneous output and input handshake with chain_start=0, chain with the out_data being handed off (bypass), not the stale register.
REQ-028 SHALL, without AES_CBC_EN, omit iv, chain_start and the chain register entirely, giving pure ECB operation.

Structure
REQ-029 SHALL place block_t (logic [127:0]), the Rcon table/function, NUM_ROUNDS=10 and the legal-UNROLL check in shared package aes_pkg.
REQ-030 SHALL instantiate sub-module aes_round_unit, UNROLL times in a chain; each instance performs one round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey) and the matching key-expansion step, reusing existing sub_bytes, shift_rows, mix_columns and key_schedule.

Verification
REQ-031 SHALL check, for each UNROLL in {1,2,5,10}: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a with latency 10/5/2/1 edges.
REQ-032 SHALL check key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32.
REQ-033 SHALL check backpressure: out_ready low 7 cycles after out_valid -> out_data constant, in_ready=0, and exactly one output handshake.
REQ-034 SHALL check back-to-back streaming of 8 random blocks with in_valid=out_ready=1 -> one output per N+1 cycles, matching the reference model.
REQ-035 SHALL check reset mid-RUN (UNROLL=1, rst at cycle 4) -> out_valid stays 0, and the next block encrypts correctly.
REQ-036 SHALL check, with AES_CBC_EN, iv=0, block 1 = C.1 pt with chain_start=1 -> 69c4e0d8...c55a; block 2 = 69d5c2eb2e2e624750541d3bbc692ba5 with chain_start=0 in the same cycle as the output handshake -> 69c4e0d86a7b0430d8cdb78070b4c55a again.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level transforms (S-box, ShiftRows,
// MixColumns, key-expansion step) used by the round unit and the top level.
package aes_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } aes_state_t;

    localparam int NUM_ROUNDS = 10;

    // Row r holds S-box outputs for inputs 16*r .. 16*r+15, index 0 leftmost.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic unroll_legal(input int u);
        return (u == 1) || (u == 2) || (u == 5) || (u == 10);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic block_t sub_bytes(input block_t s);
        block_t r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = SBOX[s[8*i +: 8]];
        end
        return r;
    endfunction

    // Byte n sits at [127-8n -: 8]; row = n%4, column = n/4.
    function automatic block_t shift_rows(input block_t s);
        block_t r;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
            end
        end
        return r;
    endfunction

    function automatic block_t mix_columns(input block_t s);
        block_t r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic block_t key_schedule(input block_t k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {SBOX[w3[23:16]] ^ rc, SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES-128 encryption round plus the matching key-expansion step;
// rnd is the absolute round number 1..10 and drives both Rcon and the MixColumns skip.
module aes_round_unit
    import aes_pkg::*;
(
    input  logic [127:0] blk,
    input  logic [127:0] rkey,
    input  logic [3:0]   rnd,
    output logic [127:0] nxt_blk,
    output logic [127:0] nxt_key
);

    block_t shifted;

    always_comb begin
        nxt_key = key_schedule(rkey, rcon(rnd));
        shifted = shift_rows(sub_bytes(blk));
        if (rnd == 4'(NUM_ROUNDS)) begin
            nxt_blk = shifted ^ nxt_key;
        end else begin
            nxt_blk = mix_columns(shifted) ^ nxt_key;
        end
    end

endmodule

// File: rtl/aes_128_unroll.sv
// Iterative AES-128 encryptor running UNROLL chained rounds per clock with on-the-fly keys.
// Define AES_CBC_EN to add CBC chaining (iv and chain_start ports plus chain register).
module aes_128_unroll
    import aes_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] key,
`ifdef AES_CBC_EN
    input  logic [127:0] iv,
    input  logic         chain_start,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    if (!unroll_legal(UNROLL)) begin : g_bad_unroll
        $error("aes_128_unroll: UNROLL must be one of 1, 2, 5, 10");
    end

    localparam logic [3:0] STEP = 4'(UNROLL);
    localparam logic [3:0] LAST = 4'(NUM_ROUNDS) - STEP;

    aes_state_t state, state_nxt;
    logic [3:0] round_cnt;
    block_t     blk_q, key_q;
    block_t     pre_blk;
    logic       in_hs, out_hs;
    block_t     chain_blk [UNROLL+1];
    block_t     chain_key [UNROLL+1];

    assign out_valid = (state == DONE);
    assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign out_data  = out_valid ? blk_q : '0;

`ifdef AES_CBC_EN
    block_t chain_q;
    block_t chain_src;

    // On a same-cycle hand-off the register has not yet captured out_data.
    always_comb begin
        chain_src = chain_q;
        if (chain_start) begin
            chain_src = iv;
        end else if (out_hs) begin
            chain_src = out_data;
        end
    end

    assign pre_blk = in_data ^ chain_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else if (out_hs) begin
            chain_q <= out_data;
        end
    end
`else
    assign pre_blk = in_data;
`endif

    assign chain_blk[0] = blk_q;
    assign chain_key[0] = key_q;

    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        aes_round_unit u_round (
            .blk     (chain_blk[j]),
            .rkey    (chain_key[j]),
            .rnd     (round_cnt + 4'(j + 1)),
            .nxt_blk (chain_blk[j+1]),
            .nxt_key (chain_key[j+1])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_hs) state_nxt = RUN;
            RUN:  if (round_cnt == LAST) state_nxt = DONE;
            DONE: begin
                if (in_hs) begin
                    state_nxt = RUN;
                end else if (out_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            round_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (in_hs) begin
                round_cnt <= '0;
            end else if (state == RUN) begin
                round_cnt <= round_cnt + STEP;
            end
        end
    end

    // Datapath registers: only ever visible through out_data once DONE, so no reset.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            blk_q <= pre_blk ^ key;
            key_q <= key;
        end else if (state == RUN) begin
            blk_q <= chain_blk[UNROLL];
            key_q <= chain_key[UNROLL];
        end
    end

endmodule

// File: tb/tb_aes_128_unroll.sv
// Directed bench for aes_128_unroll: four instances (UNROLL 1/2/5/10) checked against
// FIPS-197 vectors and an independent byte-level AES model.
module tb_aes_128_unroll;

    localparam int NI = 4;
    localparam int UNR [NI] = '{1, 2, 5, 10};

    localparam logic [127:0] C1KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BKEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BPT    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] BCT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CBCPT2 = 128'h69d5c2eb2e2e624750541d3bbc692ba5;

    logic clk = 1'b0;
    logic rst;
    logic [NI-1:0] in_valid_v, in_ready_v, out_valid_v, out_ready_v;
    logic [127:0]  in_data, key;
    logic [127:0]  out_data_v [NI];
`ifdef AES_CBC_EN
    logic [127:0]  iv;
    logic          chain_start;
`endif
    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt0;
    logic [7:0] sb [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_128_unroll #(.UNROLL(UNR[g])) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (in_valid_v[g]),
            .in_ready    (in_ready_v[g]),
            .in_data     (in_data),
            .key         (key),
`ifdef AES_CBC_EN
            .iv          (iv),
            .chain_start (chain_start),
`endif
            .out_valid   (out_valid_v[g]),
            .out_ready   (out_ready_v[g]),
            .out_data    (out_data_v[g])
        );
    end

    always @(posedge clk or posedge rst) begin
        if (rst) hs_cnt0 <= 0;
        else if (out_valid_v[0] && out_ready_v[0]) hs_cnt0 <= hs_cnt0 + 1;
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: GF(2^8) arithmetic, S-box derived from field inverses.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [16];
        logic [7:0] a0, a1, a2, a3, rc, k0, k1, k2, k3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ w[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) s[4*c+rw] = t[4*((c+rw)%4)+rw];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            k0 = sb[w[13]] ^ rc; k1 = sb[w[14]]; k2 = sb[w[15]]; k3 = sb[w[12]];
            w[0] = w[0] ^ k0; w[1] = w[1] ^ k1; w[2] = w[2] ^ k2; w[3] = w[3] ^ k3;
            for (int i = 4; i < 16; i++) w[i] = w[i] ^ w[i-4];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
            rc = gmul(rc, 8'h02);
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic start_block(input int g, input logic [127:0] pt, input logic [127:0] k);
        @(negedge clk);
        in_valid_v[g] = 1'b1;
        in_data = pt;
        key = k;
        chk($sformatf("u%0d_in_ready_idle", UNR[g]), 128'(in_ready_v[g]), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid_v[g] = 1'b0;
    endtask

    task automatic wait_out(input int g, output int lat);
        lat = 0;
        while (!out_valid_v[g] && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic take_out(input int g);
        out_ready_v[g] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_v[g] = 1'b0;
        chk($sformatf("u%0d_out_valid_after_hs", UNR[g]), 128'(out_valid_v[g]), 128'd0);
    endtask

    task automatic run_vec(input int g, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] ct, input string name);
        int lat;
        start_block(g, pt, k);
        wait_out(g, lat);
        chk($sformatf("u%0d_%s_latency", UNR[g], name), 128'(lat), 128'(10 / UNR[g]));
        chk($sformatf("u%0d_%s_ct", UNR[g], name), out_data_v[g], ct);
        take_out(g);
    endtask

    task automatic stream(input int g);
        logic [127:0] pt [8];
        logic [127:0] kk [8];
        logic [127:0] ex [8];
        int ii, oi, last, n;
        n = 10 / UNR[g];
        for (int i = 0; i < 8; i++) begin
            pt[i] = {$urandom, $urandom, $urandom, $urandom};
            kk[i] = {$urandom, $urandom, $urandom, $urandom};
            ex[i] = aes_ref(pt[i], kk[i]);
        end
        ii = 0; oi = 0; last = 0;
        out_ready_v[g] = 1'b1;
        for (int cyc = 0; cyc < 200 && oi < 8; cyc++) begin
            @(negedge clk);
            if (out_valid_v[g]) begin
                chk($sformatf("u%0d_stream_ct%0d", UNR[g], oi), out_data_v[g], ex[oi]);
                if (oi > 0) chk($sformatf("u%0d_stream_gap%0d", UNR[g], oi), 128'(cyc - last), 128'(n + 1));
                last = cyc;
                oi++;
            end
            if (ii < 8) begin
                in_valid_v[g] = 1'b1;
                in_data = pt[ii];
                key = kk[ii];
                if (in_ready_v[g]) ii++;
            end else begin
                in_valid_v[g] = 1'b0;
            end
        end
        @(negedge clk);
        out_ready_v[g] = 1'b0;
        in_valid_v[g] = 1'b0;
        chk($sformatf("u%0d_stream_count", UNR[g]), 128'(oi), 128'd8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded %0d ns", 200000);
        $fatal(1);
    end

    initial begin
        logic [127:0] c0, bp_pt, bp_key;
        int hs0, lat;
        logic seen;
        rst = 1'b1;
        in_valid_v = '0;
        out_ready_v = '0;
        in_data = '0;
        key = '0;
`ifdef AES_CBC_EN
        iv = '0;
        chain_start = 1'b1;
`endif
        build_sbox();
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 128'(in_ready_v), 128'd0);
        chk("reset_out_valid", 128'(out_valid_v), 128'd0);
        chk("reset_out_data", out_data_v[0], 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", 128'(in_ready_v), 128'hf);

        for (int g = 0; g < NI; g++) run_vec(g, C1PT, C1KEY, C1CT, "c1");
        run_vec(0, BPT, BKEY, BCT, "b");
        run_vec(3, BPT, BKEY, BCT, "b");

        // Backpressure: hold out_ready low for 7 cycles with in_valid offered.
        bp_pt = 128'hdeadbeef0123456789abcdeffedcba98;
        bp_key = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        start_block(0, bp_pt, bp_key);
        wait_out(0, lat);
        c0 = out_data_v[0];
        hs0 = hs_cnt0;
        chk("bp_ct", c0, aes_ref(bp_pt, bp_key));
        in_valid_v[0] = 1'b1;
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_data", out_data_v[0], c0);
            chk("bp_hold_valid", 128'(out_valid_v[0]), 128'd1);
            chk("bp_in_ready", 128'(in_ready_v[0]), 128'd0);
        end
        in_valid_v[0] = 1'b0;
        take_out(0);
        repeat (3) @(negedge clk);
        chk("bp_one_handshake", 128'(hs_cnt0 - hs0), 128'd1);

        stream(1);
        stream(0);

        // Reset in the middle of a RUN.
        start_block(0, C1PT, C1KEY);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(out_valid_v[0]), 128'd0);
        chk("midrst_in_ready", 128'(in_ready_v[0]), 128'd0);
        chk("midrst_out_data", out_data_v[0], 128'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid_v[0]) seen = 1'b1;
        end
        chk("midrst_no_output", 128'(seen), 128'd0);
        run_vec(0, BPT, BKEY, BCT, "after_rst");

`ifdef AES_CBC_EN
        iv = '0;
        chain_start = 1'b1;
        start_block(0, C1PT, C1KEY);
        wait_out(0, lat);
        chk("cbc_blk1_ct", out_data_v[0], C1CT);
        out_ready_v[0] = 1'b1;
        in_valid_v[0] = 1'b1;
        in_data = CBCPT2;
        key = C1KEY;
        chain_start = 1'b0;
        chk("cbc_blk2_in_ready", 128'(in_ready_v[0]), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b0;
        chain_start = 1'b1;
        wait_out(0, lat);
        chk("cbc_blk2_latency", 128'(lat), 128'd10);
        chk("cbc_blk2_ct", out_data_v[0], C1CT);
        take_out(0);
        chain_start = 1'b0;
        start_block(0, CBCPT2, C1KEY);
        chain_start = 1'b1;
        wait_out(0, lat);
        chk("cbc_blk3_ct", out_data_v[0], C1CT);
        take_out(0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
